// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, flag bit positions and FSM state type for alu_seq.
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;

  // flags = {illegal, overflow, negative, zero}
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ILL  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one multiplier bit per cycle.
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      count;
  logic               active;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = active && (count == CW'(WIDTH - 1));
  // The final partial sum is exposed combinationally so the result lands on the last iteration edge.
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      count  <= '0;
      active <= 1'b1;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, status flags, shifts and iterative multiply.
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]    op1,
  input  logic [WIDTH-1:0]    op2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH:0]      out,
  output logic [3:0]          flags
);

  localparam int SW = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic               busy;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     res;
  logic               res_ovf;
  logic               res_ill;
  logic               load;
  logic [WIDTH:0]     load_out;
  logic               load_ovf;
  logic               load_ill;

  assign busy      = (state == MUL);
  assign in_ready  = rst_n && !busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alu_op == OP_WIDTH'(OP_MUL));
  assign sh        = op2[SW-1:0];

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_ill = 1'b0;
    case (alu_op)
      OP_WIDTH'(OP_NOP): res = '0;
      OP_WIDTH'(OP_ADD): begin
        res     = {1'b0, op1} + {1'b0, op2};
        res_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_WIDTH'(OP_SUB): begin
        res     = {1'b0, op1} - {1'b0, op2};
        res_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_WIDTH'(OP_AND): res = {1'b0, op1 & op2};
      OP_WIDTH'(OP_OR):  res = {1'b0, op1 | op2};
      OP_WIDTH'(OP_XOR): res = {1'b0, op1 ^ op2};
      OP_WIDTH'(OP_SHL): res = {1'b0, op1} << sh;
      OP_WIDTH'(OP_SHR): res = {1'b0, op1 >> sh};
      OP_WIDTH'(OP_MUL): res = '0;
      default:           res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A MUL completion only happens while busy, so it never competes with a single-cycle accept.
  assign load     = (accept && !mul_start) || (busy && mul_done);
  assign load_out = busy ? {|product[2*WIDTH-1:WIDTH], product[WIDTH-1:0]} : res;
  assign load_ovf = busy ? 1'b0 : res_ovf;
  assign load_ill = busy ? 1'b0 : res_ill;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out              <= load_out;
      flags[FLAG_ZERO] <= (load_out[WIDTH-1:0] == '0);
      flags[FLAG_NEG]  <= load_out[WIDTH-1];
      flags[FLAG_OVF]  <= load_ovf;
      flags[FLAG_ILL]  <= load_ill;
      out_valid        <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational CPU ALU. It adds a valid/ready handshake on both sides, a status-flag output, shift operations and an iterative unsigned multiply. It sits in the pipelined CPU's execute stage, between operand fetch/decode and writeback, and it back-pressures decode while a multi-cycle operation is in flight.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥ 4, power of two)
- OP_WIDTH, 4, opcode width in bits

Ports:
- clk  in  1  clock; every register updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands and opcode are valid
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  OP_WIDTH  opcode
- op1  in  WIDTH  first operand
- op2  in  WIDTH  second operand
- out_valid  out  1  result and flags are valid
- out_ready  in  1  consumer takes the result this cycle
- out  out  WIDTH+1  result; bit WIDTH is carry/borrow/overflow-out
- flags  out  4  {illegal, overflow, negative, zero}

## Operation
- Accept: in_valid && in_ready at a rising edge.
- in_ready = rst_n && !busy && (!out_valid || out_ready).
- Opcodes and results:
  - 0000 NOP: out = 0.
  - 0001 ADD: op1+op2, zero-extended to WIDTH+1.
  - 0010 SUB: op1−op2 in WIDTH+1 bits; out[WIDTH] is the borrow.
  - 0011 AND, 0100 OR, 0101 XOR: bitwise, with out[WIDTH]=0.
  - 0110 SHL: ({1'b0,op1} << sh) truncated to WIDTH+1, where sh = op2[clog2(WIDTH)-1:0]. out[WIDTH] is the last bit shifted out.
  - 0111 SHR: {1'b0, op1 >> sh}, logical shift.
  - 1000 MUL: unsigned. out[WIDTH-1:0] is the low half of the product; out[WIDTH] = |high half.
  - 1001–1111 (and any wider code): out = 0, illegal = 1.
- Flags are computed on the registered result:
  - zero: out[WIDTH-1:0] == 0.
  - negative: out[WIDTH-1].
  - overflow: two's-complement overflow for ADD and SUB only, 0 for all other ops.
  - illegal: as defined above.
- FSM states:
  - IDLE: a non-MUL accept loads out/flags next edge and sets out_valid. A MUL accept goes to MUL.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH iterations. On the last iteration it loads out/flags, sets out_valid and returns to IDLE. busy = 1 throughout.
- out_valid clears on out_ready unless a new accept happens in the same cycle, in which case it stays set.
- out and flags hold stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low at an edge): out = 0, flags = 0, out_valid = 0, state = IDLE, iteration counter = 0, in_ready = 0 while rst_n is low.
- Reset mid-MUL aborts the operation. No result is emitted.
- Single-cycle ops: latency 1 cycle. Throughput is 1 per cycle while out_ready stays high.
- MUL: out_valid rises WIDTH cycles after the accept edge (8 for WIDTH=8). in_ready is 0 for those cycles.
- Back-to-back: an accept in the same cycle as out_ready replaces the result with no bubble.
- An output stall (out_valid && !out_ready) forces in_ready = 0, so no result is ever overwritten or lost.
- The MUL result is written only into an empty output slot. This is guaranteed by the in_ready rule.

## Structure
- alu_pkg holds the opcode localparams (OP_NOP … OP_MUL), the flag bit indices, and the FSM state enum (IDLE, MUL).
- One sub-module, alu_mul_seq, is the iterative shift-add multiplier:
  - inputs: start, a, b
  - outputs: done, product[2*WIDTH-1:0]
  - owns the iteration counter.
- The top level owns the handshake, the single-cycle datapath, flag generation and the output register.

## Test plan
All scenarios use WIDTH=8.
- Reset then ADD 0xFF+0x01, out_ready=1 → next cycle out=0x100, zero=1, overflow=0, out_valid for exactly 1 cycle.
- SUB 0x80−0x01 → out=0x07F, overflow=1, negative=0. SUB 0x00−0x01 → out=0x1FF, negative=1.
- SHL 0x81 by 1 → out=0x102. SHR 0x80 by 7 → out=0x001. Opcode 0xA → out=0, illegal=1.
- MUL 0x0F×0x11 → in_ready low 8 cycles, then out=0x0FF, carry=0. MUL 0xFF×0xFF → out=0x101 (low half 0x01, out[8]=1).
- out_ready held low 3 cycles with in_valid high → in_ready=0, out stable. On release, 1-cycle handoff then the next result. Streaming 16 ADDs with out_ready=1 → 16 consecutive out_valid cycles.
- rst_n low at cycle 4 of a MUL → out_valid=0, out=0, in_ready=1 on the first cycle after rst_n returns high, no stale result.
